// File: rtl/regbus_arbiter.sv
// regbus_arbiter: shares the single register-bank port between the I2C transfer strobe and a core req/gnt master.
// Latency: i2c_xfc -> bank_en in 2 cycles, core_req -> bank_en/core_gnt in 1 cycle; read rvalid RD_LAT+1 cycles after bank_en.
// Backpressure: core is held off by withholding core_gnt; I2C cannot stall, so a strobe hitting a full buffer is dropped and sets sticky i2c_overrun.
//
// Ports:
//   Clock, reset             rising-edge clock, synchronous active-high reset
//   i2c_xfc/op/addr/data     one-cycle transfer strobe and its fields from the I2C serializer
//   i2c_rdata/rvalid         I2C read return (data holds until the next I2C return)
//   i2c_overrun              sticky flag, strobe arrived while the pending buffer was full
//   core_req/we/addr/wdata   core request, fields stable until core_gnt
//   core_gnt                 one-cycle accept pulse, coincides with the core's bank_en
//   core_rdata/rvalid        core read return (data holds until the next core return)
//   bank_en/we/addr/wdata    bank access strobe and fields (fields hold while idle)
//   bank_rdata               bank read data, valid RD_LAT cycles after bank_en
// Build option: define REGBUS_RR_EN for round-robin tie-breaking; default is fixed I2C priority.
module regbus_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              i2c_xfc,
    input  logic              i2c_op,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_data,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rvalid,
    output logic              i2c_overrun,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    // WAIT_RD counts down to zero; zero marks its last cycle.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic              pend_vld;
    logic              pend_op;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_dat;
    logic              own_i2c;     // owner of the access in flight
    logic [1:0]        lat_cnt;
    logic              start;       // IDLE with something to serve
    logic              pick_i2c;    // arbitration result, meaningful with start
    logic              free_pend;   // pending entry leaves on this edge

    assign start     = (state == IDLE) && (pend_vld || core_req);
    assign free_pend = start && pick_i2c;

`ifdef REGBUS_RR_EN
    // Ties go to whoever did not own the previous access.
    logic last_owner_core;

    always_ff @(posedge Clock) begin
        if (reset) begin
            last_owner_core <= 1'b1;
        end else if (start) begin
            last_owner_core <= ~pick_i2c;
        end
    end

    assign pick_i2c = pend_vld && (!core_req || last_owner_core);
`else
    // Fixed priority: a pending I2C transfer always wins.
    assign pick_i2c = pend_vld;
`endif

    // One-entry buffer for the non-stallable I2C strobe. A strobe on the
    // same edge the entry is handed to ISSUE refills it instead of overrunning.
    always_ff @(posedge Clock) begin
        if (reset) begin
            pend_vld    <= 1'b0;
            pend_op     <= 1'b0;
            pend_addr   <= '0;
            pend_dat    <= '0;
            i2c_overrun <= 1'b0;
        end else begin
            if (free_pend) begin
                pend_vld <= 1'b0;
            end
            if (i2c_xfc) begin
                if (!pend_vld || free_pend) begin
                    pend_vld  <= 1'b1;
                    pend_op   <= i2c_op;
                    pend_addr <= i2c_addr;
                    pend_dat  <= i2c_data;
                end else begin
                    i2c_overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bank_en   = 1'b0;
        core_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bank_en   = 1'b1;
                core_gnt  = ~own_i2c;
                state_nxt = bank_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (lat_cnt == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state       <= IDLE;
            own_i2c     <= 1'b0;
            lat_cnt     <= 2'd0;
            bank_we     <= 1'b0;
            bank_addr   <= '0;
            bank_wdata  <= '0;
            i2c_rdata   <= '0;
            i2c_rvalid  <= 1'b0;
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            i2c_rvalid  <= 1'b0;
            core_rvalid <= 1'b0;

            // Bank fields are loaded only when an access starts, so they
            // hold their last values while idle.
            if (start) begin
                own_i2c    <= pick_i2c;
                bank_we    <= pick_i2c ? pend_op   : core_we;
                bank_addr  <= pick_i2c ? pend_addr : core_addr;
                bank_wdata <= pick_i2c ? pend_dat  : core_wdata;
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT_RD) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if ((state == WAIT_RD) && (lat_cnt == 2'd0)) begin
                if (own_i2c) begin
                    i2c_rdata  <= bank_rdata;
                    i2c_rvalid <= 1'b1;
                end else begin
                    core_rdata  <= bank_rdata;
                    core_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: directed and randomized checks of regbus_arbiter against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); the core driver holds its request until granted.
module tb_regbus_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;
    localparam int MEM_N  = 2 ** ADDR_W;

    logic              Clock = 1'b0;
    logic              reset;
    logic              i2c_xfc, i2c_op;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_data;
    logic [DATA_W-1:0] i2c_rdata;
    logic              i2c_rvalid, i2c_overrun;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;
    logic              bank_en, bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata;

    regbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .Clock(Clock), .reset(reset),
        .i2c_xfc(i2c_xfc), .i2c_op(i2c_op), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
        .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid), .i2c_overrun(i2c_overrun),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata)
    );

    always #5 Clock = ~Clock;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i) ^ 8'h2C;
    endfunction

    // Bank: memory with RD_LAT read pipeline; idle slots carry junk.
    logic [DATA_W-1:0] bank_mem [0:MEM_N-1];
    logic [DATA_W-1:0] rd_pipe  [0:2];
    assign bank_rdata = rd_pipe[RD_LAT-1];

    always @(posedge Clock) begin
        if (bank_en && bank_we) bank_mem[bank_addr] <= bank_wdata;
        rd_pipe[0] <= (bank_en && !bank_we) ? bank_mem[bank_addr] : DATA_W'($urandom);
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        if (reset) begin
            for (int i = 0; i < MEM_N; i++) bank_mem[i] <= init_val(i);
        end
    end

    // Transaction-level reference model state.
    int                n_checks = 0;
    int                n_err    = 0;
    int                cyc      = 0;
    int                m_free_at;
    bit                m_pv, m_pop, m_last_core, m_ovr;
    logic [ADDR_W-1:0] m_paddr;
    logic [DATA_W-1:0] m_pdat;
    logic [DATA_W-1:0] ref_mem [0:MEM_N-1];
    int                rv_at;
    bit                rv_i2c;
    logic [DATA_W-1:0] rv_dat;
    bit                e_en, e_we, e_gnt, e_irv, e_crv, e_ovr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_ird, e_crd;
    bit                obs_own [$];   // 1 = core owned the access
    bit                exp_own [3];

    // Random-phase driver state.
    bit                c_active, c_drop, c_we, r_rst, r_xfc, r_op, got;
    logic [ADDR_W-1:0] c_a, r_a;
    logic [DATA_W-1:0] c_d, r_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("bank_en",     32'(bank_en),     32'(e_en));
        chk("bank_we",     32'(bank_we),     32'(e_we));
        chk("bank_addr",   32'(bank_addr),   32'(e_addr));
        chk("bank_wdata",  32'(bank_wdata),  32'(e_wdata));
        chk("core_gnt",    32'(core_gnt),    32'(e_gnt));
        chk("i2c_rvalid",  32'(i2c_rvalid),  32'(e_irv));
        chk("i2c_rdata",   32'(i2c_rdata),   32'(e_ird));
        chk("core_rvalid", 32'(core_rvalid), 32'(e_crv));
        chk("core_rdata",  32'(core_rdata),  32'(e_crd));
        chk("i2c_overrun", 32'(i2c_overrun), 32'(e_ovr));
        if (bank_en === 1'b1) obs_own.push_back(core_gnt === 1'b1);
    endtask

    task automatic model_reset();
        m_free_at = 0; m_pv = 0; m_last_core = 1; m_ovr = 0; rv_at = -1;
        e_we = 0; e_addr = '0; e_wdata = '0; e_ird = '0; e_crd = '0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);
    endtask

    // Drive one cycle of inputs, predict the next cycle, advance and compare.
    task automatic step(input bit rst, input bit xfc, input bit op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit req, input bit we,
                        input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
        bit take_i2c, pv_old, n_en, n_gnt, acc_we;
        logic [ADDR_W-1:0] acc_a;
        logic [DATA_W-1:0] acc_d;
        reset = rst; i2c_xfc = xfc; i2c_op = op; i2c_addr = a; i2c_data = d;
        core_req = req; core_we = we; core_addr = ca; core_wdata = cd;
        n_en = 0; n_gnt = 0; take_i2c = 0;
        if (rst) begin
            model_reset();
        end else begin
            pv_old = m_pv;
            if (cyc >= m_free_at && (m_pv || req)) begin
`ifdef REGBUS_RR_EN
                take_i2c = m_pv && (!req || m_last_core);
                m_last_core = !take_i2c;
`else
                take_i2c = m_pv;
`endif
                if (take_i2c) begin
                    acc_we = m_pop; acc_a = m_paddr; acc_d = m_pdat; m_pv = 0;
                end else begin
                    acc_we = we; acc_a = ca; acc_d = cd;
                end
                n_en = 1; n_gnt = !take_i2c;
                e_we = acc_we; e_addr = acc_a; e_wdata = acc_d;
                if (acc_we) begin
                    ref_mem[acc_a] = acc_d;
                    m_free_at = cyc + 2;
                end else begin
                    rv_at = cyc + 2 + RD_LAT; rv_i2c = take_i2c; rv_dat = ref_mem[acc_a];
                    m_free_at = rv_at;
                end
            end
            if (xfc) begin
                if (!pv_old || take_i2c) begin
                    m_pv = 1; m_pop = op; m_paddr = a; m_pdat = d;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        e_en = n_en; e_gnt = n_gnt; e_ovr = m_ovr; e_irv = 0; e_crv = 0;
        if (rv_at == cyc + 1) begin
            if (rv_i2c) begin e_irv = 1; e_ird = rv_dat; end
            else        begin e_crv = 1; e_crd = rv_dat; end
        end
        @(posedge Clock); #1; cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
`ifdef REGBUS_RR_EN
        exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0;
`else
        exp_own[0] = 0; exp_own[1] = 0; exp_own[2] = 0;
`endif
        model_reset();
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        chk("rst_bank_en", 32'(bank_en), 32'd0);
        chk("rst_bank_addr", 32'(bank_addr), 32'd0);
        chk("rst_overrun", 32'(i2c_overrun), 32'd0);
        idle(2);

        // I2C write: xfc at C0 -> access at C2.
        step(0, 1, 1, 11'h123, 8'hA5, 0, 0, '0, '0);
        idle(1);
        chk("wr_bank_en", 32'(bank_en), 32'd1);
        chk("wr_bank_we", 32'(bank_we), 32'd1);
        chk("wr_bank_addr", 32'(bank_addr), 32'h123);
        chk("wr_bank_wdata", 32'(bank_wdata), 32'hA5);
        idle(3);
        chk("wr_no_rvalid", 32'(i2c_rvalid), 32'd0);

        // I2C read of 0x010 (bank holds 0x3C): rvalid at C5.
        step(0, 1, 0, 11'h010, 8'h00, 0, 0, '0, '0);
        idle(3);
        chk("rd_early_rvalid", 32'(i2c_rvalid), 32'd0);
        idle(1);
        chk("rd_rvalid", 32'(i2c_rvalid), 32'd1);
        chk("rd_rdata", 32'(i2c_rdata), 32'h3C);
        chk("rd_core_rvalid", 32'(core_rvalid), 32'd0);
        idle(2);

        // Core write held until grant, dropped afterwards.
        step(0, 0, 0, '0, '0, 1, 1, 11'h7FF, 8'h01);
        chk("cw_gnt", 32'(core_gnt), 32'd1);
        chk("cw_bank_en", 32'(bank_en), 32'd1);
        chk("cw_bank_addr", 32'(bank_addr), 32'h7FF);
        chk("cw_bank_wdata", 32'(bank_wdata), 32'h01);
        step(0, 0, 0, '0, '0, 1, 1, 11'h7FF, 8'h01);
        chk("cw_no_repeat", 32'(bank_en), 32'd0);
        idle(2);
        chk("cw_no_repeat2", 32'(core_gnt), 32'd0);

        // Ties: I2C refilled whenever its buffer is empty, core always requesting.
        obs_own.delete();
        for (int k = 0; k < 12; k++)
            step(0, !m_pv, 1, 11'(k + 32), 8'(k), k > 0, 1, 11'h055, 8'h77);
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            step(0, 0, 0, '0, '0, 1, 1, 11'h055, 8'h77);
            if (e_gnt) got = 1;
        end
        chk("tie_core_served", 32'(got), 32'd1);
        step(0, 0, 0, '0, '0, 1, 1, 11'h055, 8'h77);
        idle(3);
        chk("tie_count", 32'(obs_own.size() >= 3), 32'd1);
        for (int k = 0; k < 3; k++) chk("tie_owner", 32'(obs_own[k]), 32'(exp_own[k]));

        // Overrun: two strobes while the core read holds the bank.
        step(0, 0, 0, '0, '0, 1, 0, 11'h200, 8'h00);
        chk("ov_gnt", 32'(core_gnt), 32'd1);
        step(0, 1, 1, 11'h0AA, 8'h11, 1, 0, 11'h200, 8'h00);
        step(0, 1, 1, 11'h0BB, 8'h22, 0, 0, '0, '0);
        chk("ov_set", 32'(i2c_overrun), 32'd1);
        idle(8);
        chk("ov_sticky", 32'(i2c_overrun), 32'd1);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        chk("ov_cleared", 32'(i2c_overrun), 32'd0);
        idle(1);

        // Second strobe on the edge the buffer enters ISSUE: accepted.
        obs_own.delete();
        step(0, 1, 1, 11'h0CC, 8'h33, 0, 0, '0, '0);
        step(0, 1, 1, 11'h0DD, 8'h44, 0, 0, '0, '0);
        idle(6);
        chk("refill_no_ovr", 32'(i2c_overrun), 32'd0);
        chk("refill_accesses", 32'(obs_own.size()), 32'd2);

        // Reset during WAIT_RD of a core read.
        step(0, 0, 0, '0, '0, 1, 0, 11'h300, 8'h00);
        step(0, 0, 0, '0, '0, 1, 0, 11'h300, 8'h00);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        chk("mid_rst_en", 32'(bank_en), 32'd0);
        chk("mid_rst_addr", 32'(bank_addr), 32'd0);
        chk("mid_rst_crd", 32'(core_rdata), 32'd0);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("mid_rst_no_rvalid", 32'(core_rvalid), 32'd0);
        end

        // Randomized traffic against the model.
        c_active = 0; c_drop = 0;
        for (int i = 0; i < 1500; i++) begin
            if (c_drop) begin c_active = 0; c_drop = 0; end
            if (!c_active && $urandom_range(0, 99) < 40) begin
                c_active = 1;
                c_we = 1'($urandom);
                c_a  = 11'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 11'h7F0 : 11'h000);
                c_d  = 8'($urandom);
            end
            r_rst = ($urandom_range(0, 299) == 0);
            r_xfc = ($urandom_range(0, 99) < 30);
            r_op  = 1'($urandom);
            r_a   = 11'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 11'h7F0 : 11'h000);
            r_d   = 8'($urandom);
            step(r_rst, r_xfc, r_op, r_a, r_d, c_active, c_we, c_a, c_d);
            if (e_gnt) c_drop = 1;
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

- Shares the chip's single register-bank port between two requesters:
  - the I2C serializer's transfer strobe (op/address/data plus a one-cycle xfc pulse);
  - an on-chip core master using a req/gnt handshake.
- Buffers the non-stallable I2C strobe, arbitrates, and sequences bank accesses with a fixed read latency.
- Returns read data to whichever requester owns the access.

## Interface
- ADDR_W, 11, register-bank address width
- DATA_W, 8, register-bank data width
- RD_LAT, 1, bank read latency in cycles (legal 1..3)

- Clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i2c_xfc  in  1  one-cycle transfer strobe from serializer
- i2c_op  in  1  1=write, 0=read; sampled with i2c_xfc
- i2c_addr  in  ADDR_W  transfer address; sampled with i2c_xfc
- i2c_data  in  DATA_W  write data; sampled with i2c_xfc
- i2c_rdata  out  DATA_W  read data for I2C; holds until next I2C read return
- i2c_rvalid  out  1  one-cycle pulse, i2c_rdata valid
- i2c_overrun  out  1  sticky; xfc arrived while buffer full
- core_req  in  1  core request; fields stable until core_gnt
- core_we  in  1  1=write, 0=read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  one-cycle pulse, request accepted
- core_rdata  out  DATA_W  read data for core; holds until next core read return
- core_rvalid  out  1  one-cycle pulse, core_rdata valid
- bank_en  out  1  one-cycle access strobe to bank
- bank_we  out  1  write enable, qualified by bank_en
- bank_addr  out  ADDR_W  access address
- bank_wdata  out  DATA_W  write data
- bank_rdata  in  DATA_W  bank read data, valid RD_LAT cycles after bank_en

## Operation
- **I2C pending buffer (1 entry):**
  - Stores op/addr/data.
  - Set on an xfc edge when empty.
  - Cleared on the edge that enters ISSUE with owner I2C.
  - An xfc on that same edge is accepted; this is not an overrun.
  - xfc while full and not freeing: strobe is dropped and i2c_overrun is set. Only reset clears i2c_overrun.
- **FSM states:** IDLE, ISSUE, WAIT_RD.
  - IDLE: if I2C pending or core_req, pick an owner, latch its fields, go to ISSUE.
  - ISSUE: bank_en=1 for exactly one cycle. core_gnt pulses in this cycle when the owner is core.
    - Write: go to IDLE.
    - Read: load the latency counter, go to WAIT_RD.
  - WAIT_RD: lasts RD_LAT cycles. On its last edge, capture bank_rdata into the owner's rdata register. Pulse the owner's rvalid next cycle, go to IDLE.
- Arbitration only in IDLE; no preemption. A single request wins regardless of policy.
- When idle: bank_we, bank_addr and bank_wdata hold their last values; only bank_en is meaningful.
- Addresses and data pass through unmodified; no arithmetic on them.
- Latency counter width: 2 bits.

## Timing
- **Reset values:** all outputs 0, FSM=IDLE, pending empty, last_owner=core.
- **I2C path:**
  - xfc high in cycle C0 → pending visible C1 → bank_en high C2 (if uncontested).
  - Read: i2c_rvalid high in cycle C2+RD_LAT+1.
- **Core path:**
  - core_req seen in IDLE at cycle C → bank_en and core_gnt high at C+1.
  - Read: core_rvalid at C+1+RD_LAT+1.
  - Core may drop or change fields the cycle after core_gnt.
- **Throughput:** one write per 2 cycles; one read per RD_LAT+2 cycles.
- **Reset mid-operation:** any state returns to IDLE next edge. The in-flight read is discarded; no rvalid pulse.
- rvalid and gnt are never asserted for two consecutive cycles.

## Configuration
- REGBUS_RR_EN defined:
  - Round-robin on ties: grant the requester that was not last_owner.
  - last_owner updates at every ISSUE.
- Undefined:
  - Fixed priority, I2C always wins ties.
  - The core can starve under continuous I2C traffic.
  - last_owner is not implemented.

## Test plan
- Reset, then I2C write xfc (op=1, addr=0x123, data=0xA5) at C0 → bank_en/bank_we=1, bank_addr=0x123, bank_wdata=0xA5 at C2; no rvalid.
- RD_LAT=2: I2C read xfc (addr=0x010), bank returns 0x3C → i2c_rvalid pulse at C5 with i2c_rdata=0x3C; core_rvalid stays 0.
- core_req write (addr=0x7FF, data=0x01) held → core_gnt and bank_en coincide one cycle after the request is seen; req dropped after gnt → no second access.
- I2C xfc and core_req pending together for three arbitrations:
  - with REGBUS_RR_EN, grant order I2C, core, I2C;
  - without it, I2C wins each tie.
- Two xfc strobes 1 cycle apart while core holds the bank → second dropped, i2c_overrun=1 and stays 1 until reset. Repeat with the second xfc on the edge entering I2C ISSUE → accepted, overrun stays 0.
- Assert reset during WAIT_RD of a core read → FSM IDLE next cycle; core_rvalid never pulses; all outputs 0.
